// File: rtl/tut4_verilog_sort_sort_unit_stall_rtl.sv
// tut4_verilog_sort_sort_unit_stall_rtl: 3-stage stable 4-element sorter with dir/signed modes and val/rdy whole-pipe stall
module tut4_verilog_sort_sort_unit_stall_rtl #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_dir,
  input  logic               in_signed,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3,
  output logic [7:0]         out_idx
);
  typedef logic [p_nbits-1:0] elem_t;
  logic stall, perm_ok;
  logic val1_q, val2_q, val3_q, val1_d, val2_d, val3_d;
  logic dir1_q, dir2_q, dir3_q, dir1_d, dir2_d, dir3_d;
  logic sgn1_q, sgn2_q, sgn3_q, sgn1_d, sgn2_d, sgn3_d;
  elem_t e1_q [4], e2_q [4], e3_q [4], e1_d [4], e2_d [4], e3_d [4];
  elem_t n1_v [4], n2_v [4], n3_v [4];
  logic [1:0] x2_q [4], x3_q [4], x2_d [4], x3_d [4];
  logic [1:0] n1_x [4], n2_x [4], n3_x [4];

  // Ties always resolve by original index, so equal values stay in input order in both directions
  function automatic void cas(input elem_t a, input elem_t b, input logic [1:0] ai, input logic [1:0] bi,
                              input logic dir, input logic sgn, output elem_t lo, output elem_t hi,
                              output logic [1:0] lo_i, output logic [1:0] hi_i);
    logic gt, lt, sw;
    gt = sgn ? $signed(a) > $signed(b) : a > b;
    lt = sgn ? $signed(a) < $signed(b) : a < b;
    sw = (dir ? lt : gt) || (a == b && ai > bi);
    lo = sw ? b : a;
    hi = sw ? a : b;
    lo_i = sw ? bi : ai;
    hi_i = sw ? ai : bi;
  endfunction

  always_comb begin
    stall = val3_q && !out_rdy;
    in_rdy = !reset && !stall;
    cas(e1_q[0], e1_q[1], 2'd0, 2'd1, dir1_q, sgn1_q, n1_v[0], n1_v[1], n1_x[0], n1_x[1]);
    cas(e1_q[2], e1_q[3], 2'd2, 2'd3, dir1_q, sgn1_q, n1_v[2], n1_v[3], n1_x[2], n1_x[3]);
    cas(e2_q[0], e2_q[2], x2_q[0], x2_q[2], dir2_q, sgn2_q, n2_v[0], n2_v[2], n2_x[0], n2_x[2]);
    cas(e2_q[1], e2_q[3], x2_q[1], x2_q[3], dir2_q, sgn2_q, n2_v[1], n2_v[3], n2_x[1], n2_x[3]);
    n3_v = e3_q;
    n3_x = x3_q;
    cas(e3_q[1], e3_q[2], x3_q[1], x3_q[2], dir3_q, sgn3_q, n3_v[1], n3_v[2], n3_x[1], n3_x[2]);
    out_val = val3_q;
    out0 = n3_v[0];
    out1 = n3_v[1];
    out2 = n3_v[2];
    out3 = n3_v[3];
    out_idx = {n3_x[3], n3_x[2], n3_x[1], n3_x[0]};
    perm_ok = ((4'b1 << n3_x[0]) | (4'b1 << n3_x[1]) | (4'b1 << n3_x[2]) | (4'b1 << n3_x[3])) == 4'hf;
    val1_d = stall ? val1_q : in_val && in_rdy;
    val2_d = stall ? val2_q : val1_q;
    val3_d = stall ? val3_q : val2_q;
    dir1_d = stall ? dir1_q : in_dir;
    dir2_d = stall ? dir2_q : dir1_q;
    dir3_d = stall ? dir3_q : dir2_q;
    sgn1_d = stall ? sgn1_q : in_signed;
    sgn2_d = stall ? sgn2_q : sgn1_q;
    sgn3_d = stall ? sgn3_q : sgn2_q;
    e1_d = '{in0, in1, in2, in3};
    e2_d = n1_v;
    x2_d = n1_x;
    e3_d = n2_v;
    x3_d = n2_x;
    if (stall) begin
      e1_d = e1_q;
      e2_d = e2_q;
      x2_d = x2_q;
      e3_d = e3_q;
      x3_d = x3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val1_q <= 1'b0;
      val2_q <= 1'b0;
      val3_q <= 1'b0;
    end else begin
      val1_q <= val1_d;
      val2_q <= val2_d;
      val3_q <= val3_d;
    end
    dir1_q <= dir1_d;
    dir2_q <= dir2_d;
    dir3_q <= dir3_d;
    sgn1_q <= sgn1_d;
    sgn2_q <= sgn2_d;
    sgn3_q <= sgn3_d;
    e1_q <= e1_d;
    e2_q <= e2_d;
    e3_q <= e3_d;
    x2_q <= x2_d;
    x3_q <= x3_d;
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({in_val, out_rdy, val1_q, val2_q, val3_q, out_val}));
  a_idx_perm: assert property (@(posedge clk) disable iff (reset) out_val |-> perm_ok);
endmodule
